// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl -- CP0-style interrupt controller placed in front of maindec.
//
// Latches rising edges of the interrupt sources into Cause.IP, qualifies them
// with Status.IE / Status.IM / Status.EXL and the branch-shadow blocker
// (intctrl), and raises exl for one cycle so maindec can replace the current
// instruction with a jump to the handler. It keeps Status (12), Cause (13)
// and EPC (14), serves MFC0 reads and MTC0 writes, and exposes EPC for ERET.
//
// Ports
//   clk      system clock
//   rst      synchronous, active-high reset
//   irq      level interrupt sources; a rising edge is a request
//   intctrl  current instruction is a branch/jump; blocks taking an interrupt
//   pc       address of the current instruction (saved into EPC on a take)
//   we       MTC0 write strobe
//   addr     CP0 register number for both read and write
//   wd       MTC0 write data
//   eret     return-from-exception strobe
//   rd       MFC0 read data (combinational)
//   exl      interrupt is taken this cycle (to maindec EXL)
//   iv       vectored mode (to maindec IV)
//   vector   handler address
//   epc      saved return address
//   irq_ack  one-hot acknowledge, high for the cycle after the take
// ---------------------------------------------------------------------------
module irq_ctrl #(
    parameter int              wide     = 32,
    parameter int              NSRC     = 4,
    parameter logic [wide-1:0] VEC_BASE = 32'h000000C0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq,
    input  logic            intctrl,
    input  logic [wide-1:0] pc,
    input  logic            we,
    input  logic [4:0]      addr,
    input  logic [wide-1:0] wd,
    input  logic            eret,
    output logic [wide-1:0] rd,
    output logic            exl,
    output logic            iv,
    output logic [wide-1:0] vector,
    output logic [wide-1:0] epc,
    output logic [NSRC-1:0] irq_ack
);

    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } state_t;

    state_t          state_reg, state_next;

    logic            ie_reg;
    logic            status_exl_reg;
    logic            iv_reg;
    logic [NSRC-1:0] im_reg;
    logic [NSRC-1:0] ip_reg;
    logic [NSRC-1:0] ip_next;
    logic [4:0]      code_reg;
    logic [wide-1:0] epc_reg;
    logic [NSRC-1:0] irq_prev_reg;
    logic [NSRC-1:0] irq_ack_reg;

    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] rising;
    logic [NSRC-1:0] win_onehot;
    logic [4:0]      win_idx;
    logic [4:0]      code_next;
    logic [wide-1:0] code_ext;
    logic            take;
    logic            mtc0;
    logic            cause_w1c;

    // Only a few bits of wd land in registers; fold the rest away.
    logic            unused_wd;
    assign unused_wd = ^wd;

    assign pend   = ip_reg & im_reg;
    assign rising = irq & ~irq_prev_reg;

    // Lowest index wins: scan downward so the last assignment is the lowest.
    always_comb begin
        win_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend[i]) begin
                win_idx = 5'(i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            assign win_onehot[gi] = (win_idx == 5'(gi));
            // A fresh edge beats a W1C clear of the same bit.
            assign ip_next[gi] = rising[gi] |
                                 (ip_reg[gi] & ~(cause_w1c & wd[8 + gi]));
        end
    endgenerate

    // Next-state and take decision.
    always_comb begin
        state_next = state_reg;
        take       = 1'b0;
        case (state_reg)
            IDLE: begin
                take = ie_reg & ~status_exl_reg & (|pend) & ~intctrl;
                if (take) begin
                    state_next = SERVICE;
                end
            end
            SERVICE: begin
                if (eret) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The instruction carrying an MTC0 is discarded when an interrupt is taken.
    assign mtc0      = we & ~take;
    assign cause_w1c = mtc0 & (addr == ADDR_CAUSE);

    always_ff @(posedge clk) begin
        if (rst) begin
            ie_reg         <= 1'b0;
            status_exl_reg <= 1'b0;
            iv_reg         <= 1'b0;
            im_reg         <= '0;
            ip_reg         <= '0;
            code_reg       <= '0;
            epc_reg        <= '0;
            irq_prev_reg   <= '0;
            irq_ack_reg    <= '0;
        end else begin
            irq_prev_reg <= irq;
            ip_reg       <= ip_next;
            irq_ack_reg  <= take ? win_onehot : '0;
            if (take) begin
                epc_reg        <= pc;
                status_exl_reg <= 1'b1;
                code_reg       <= win_idx;
            end else begin
                if (mtc0 && addr == ADDR_STATUS) begin
                    ie_reg <= wd[0];
                    iv_reg <= wd[2];
                    im_reg <= wd[8 +: NSRC];
                end
                if (mtc0 && addr == ADDR_EPC) begin
                    epc_reg <= wd;
                end
                // eret only matters while servicing; in IDLE it is a no-op.
                if (eret && state_reg == SERVICE) begin
                    status_exl_reg <= 1'b0;
                end
            end
        end
    end

    // During the take cycle the vector must already point at the winner,
    // before Cause.code has been updated.
    assign code_next = take ? win_idx : code_reg;
    assign code_ext  = {{(wide - 5){1'b0}}, code_next};

    always_comb begin
        rd = '0;
        case (addr)
            ADDR_STATUS: begin
                rd[0]           = ie_reg;
                rd[1]           = status_exl_reg;
                rd[2]           = iv_reg;
                rd[8 +: NSRC]   = im_reg;
            end
            ADDR_CAUSE: begin
                rd[6:2]         = code_reg;
                rd[8 +: NSRC]   = ip_reg;
            end
            ADDR_EPC: begin
                rd = epc_reg;
            end
            default: rd = '0;
        endcase
    end

    assign exl     = take;
    assign iv      = iv_reg;
    assign vector  = iv_reg ? (VEC_BASE + (code_ext << 3)) : VEC_BASE;
    assign epc     = epc_reg;
    assign irq_ack = irq_ack_reg;

endmodule

// File: tb/tb_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_ctrl -- self-checking bench for irq_ctrl.
// Directed table vectors, hand-written multi-cycle sequences and a random
// phase, every cycle also compared against a behavioural model of the
// controller's register rules.
// ---------------------------------------------------------------------------
module tb_irq_ctrl;

    localparam int          W  = 32;
    localparam int          N  = 4;
    localparam logic [31:0] VB = 32'h000000C0;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  irq;
    logic          intctrl;
    logic [W-1:0]  pc;
    logic          we;
    logic [4:0]    addr;
    logic [W-1:0]  wd;
    logic          eret;
    logic [W-1:0]  rd;
    logic          exl;
    logic          iv;
    logic [W-1:0]  vector;
    logic [W-1:0]  epc;
    logic [N-1:0]  irq_ack;

    irq_ctrl #(.wide(W), .NSRC(N), .VEC_BASE(VB)) dut (
        .clk     (clk),
        .rst     (rst),
        .irq     (irq),
        .intctrl (intctrl),
        .pc      (pc),
        .we      (we),
        .addr    (addr),
        .wd      (wd),
        .eret    (eret),
        .rd      (rd),
        .exl     (exl),
        .iv      (iv),
        .vector  (vector),
        .epc     (epc),
        .irq_ack (irq_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [N-1:0]  irq;
        logic          intctrl;
        logic [31:0]   pc;
        logic          we;
        logic [4:0]    addr;
        logic [31:0]   wd;
        logic          eret;
        logic          exp_exl;
        logic [N-1:0]  exp_ack;
        logic [31:0]   exp_vector;
        logic [31:0]   exp_rd;
        logic [31:0]   exp_epc;
    } vec_t;

    int checks = 0;
    int passes = 0;

    // ---------------- behavioural model ----------------
    bit          m_ie, m_exl, m_iv;
    bit          m_im   [N];
    bit          m_ip   [N];
    bit          m_prev [N];
    int          m_code;
    logic [31:0] m_epc;
    int          m_ack;     // index acknowledged this cycle, -1 for none

    logic         e_exl;
    logic         e_iv;
    logic [N-1:0] e_ack;
    logic [31:0]  e_vec;
    logic [31:0]  e_rd;

    function automatic void model_reset();
        m_ie = 0; m_exl = 0; m_iv = 0; m_code = 0; m_epc = '0; m_ack = -1;
        for (int i = 0; i < N; i++) begin
            m_im[i] = 0; m_ip[i] = 0; m_prev[i] = 0;
        end
    endfunction

    function automatic int lowest_pending();
        for (int i = 0; i < N; i++) begin
            if (m_ip[i] && m_im[i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_outputs();
        int          low;
        int          cn;
        logic [31:0] st;
        logic [31:0] ca;
        low   = lowest_pending();
        e_exl = !m_exl && m_ie && (low >= 0) && !intctrl;
        cn    = e_exl ? low : m_code;
        e_iv  = m_iv;
        e_vec = m_iv ? VB + 32'(cn * 8) : VB;
        e_ack = (m_ack >= 0) ? N'(1 << m_ack) : '0;
        st = 32'(m_ie) + 32'(m_exl) * 2 + 32'(m_iv) * 4;
        ca = 32'(m_code) * 4;
        for (int i = 0; i < N; i++) begin
            st = st + (32'(m_im[i]) << (8 + i));
            ca = ca + (32'(m_ip[i]) << (8 + i));
        end
        case (addr)
            5'd12:   e_rd = st;
            5'd13:   e_rd = ca;
            5'd14:   e_rd = m_epc;
            default: e_rd = '0;
        endcase
    endfunction

    // Applies one clock edge with the inputs currently driven.
    function automatic void model_edge();
        bit was_exl;
        int low;
        if (rst) begin
            model_reset();
            return;
        end
        was_exl = m_exl;
        low     = lowest_pending();
        m_ack   = -1;
        if (e_exl) begin
            m_epc  = pc;
            m_exl  = 1;
            m_code = low;
            m_ack  = low;
        end else begin
            if (we && addr == 5'd12) begin
                m_ie = wd[0];
                m_iv = wd[2];
                for (int i = 0; i < N; i++) m_im[i] = wd[8 + i];
            end
            if (we && addr == 5'd13) begin
                for (int i = 0; i < N; i++) if (wd[8 + i]) m_ip[i] = 0;
            end
            if (we && addr == 5'd14) m_epc = wd;
            if (eret && was_exl) m_exl = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (irq[i] && !m_prev[i]) m_ip[i] = 1;
            m_prev[i] = irq[i];
        end
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic r, input logic [N-1:0] i, input logic ic,
                                input logic [31:0] p, input logic w, input logic [4:0] a,
                                input logic [31:0] d, input logic er, input logic x_exl,
                                input logic [N-1:0] x_ack, input logic [31:0] x_vec,
                                input logic [31:0] x_rd, input logic [31:0] x_epc);
        vec_t v;
        v.rst = r; v.irq = i; v.intctrl = ic; v.pc = p; v.we = w; v.addr = a;
        v.wd = d; v.eret = er; v.exp_exl = x_exl; v.exp_ack = x_ack;
        v.exp_vector = x_vec; v.exp_rd = x_rd; v.exp_epc = x_epc;
        return v;
    endfunction

    // One cycle: drive, compare before the edge, clock, advance the model.
    task automatic run_cycle(input vec_t v, input bit use_table, input string tag);
        rst = v.rst; irq = v.irq; intctrl = v.intctrl; pc = v.pc; we = v.we;
        addr = v.addr; wd = v.wd; eret = v.eret;
        @(negedge clk);
        model_outputs();
        chk({tag, " model exl"},    32'(exl),     32'(e_exl));
        chk({tag, " model ack"},    32'(irq_ack), 32'(e_ack));
        chk({tag, " model vector"}, vector,       e_vec);
        chk({tag, " model rd"},     rd,           e_rd);
        chk({tag, " model epc"},    epc,          m_epc);
        chk({tag, " model iv"},     32'(iv),      32'(e_iv));
        if (use_table) begin
            chk({tag, " exl"},    32'(exl),     32'(v.exp_exl));
            chk({tag, " ack"},    32'(irq_ack), 32'(v.exp_ack));
            chk({tag, " vector"}, vector,       v.exp_vector);
            chk({tag, " rd"},     rd,           v.exp_rd);
            chk({tag, " epc"},    epc,          v.exp_epc);
        end
        $display("%s rst=%0b irq=%b ic=%0b we=%0b addr=%0d wd=%h eret=%0b | exl=%0b ack=%b vec=%h rd=%h epc=%h",
                 tag, rst, irq, intctrl, we, addr, wd, eret, exl, irq_ack, vector, rd, epc);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    vec_t tbl [16];
    vec_t seq [21];
    vec_t rv;
    logic [N-1:0] irq_r;

    initial begin
        // Directed table: reset, enable/take, vectored priority.
        //           rst irq    ic pc      we addr   wd        er  exl ack    vector   rd        epc
        tbl[0]  = mk(1, 4'b0000, 0, 32'h0,  0, 5'd12, 32'h0,   0,  0, 4'b0000, 32'hC0, 32'h0,   32'h0);
        tbl[1]  = mk(0, 4'b0000, 0, 32'h0,  0, 5'd12, 32'h0,   0,  0, 4'b0000, 32'hC0, 32'h0,   32'h0);
        tbl[2]  = mk(0, 4'b0000, 0, 32'h0,  0, 5'd13, 32'h0,   0,  0, 4'b0000, 32'hC0, 32'h0,   32'h0);
        tbl[3]  = mk(0, 4'b0000, 0, 32'h0,  0, 5'd14, 32'h0,   0,  0, 4'b0000, 32'hC0, 32'h0,   32'h0);
        tbl[4]  = mk(0, 4'b0001, 0, 32'h0,  0, 5'd13, 32'h0,   0,  0, 4'b0000, 32'hC0, 32'h0,   32'h0);
        tbl[5]  = mk(0, 4'b0001, 0, 32'h0,  0, 5'd13, 32'h0,   0,  0, 4'b0000, 32'hC0, 32'h100, 32'h0);
        tbl[6]  = mk(0, 4'b0001, 0, 32'h0,  1, 5'd12, 32'h101, 0,  0, 4'b0000, 32'hC0, 32'h0,   32'h0);
        tbl[7]  = mk(0, 4'b0001, 0, 32'h40, 0, 5'd12, 32'h0,   0,  1, 4'b0000, 32'hC0, 32'h101, 32'h0);
        tbl[8]  = mk(0, 4'b0001, 0, 32'h0,  0, 5'd14, 32'h0,   0,  0, 4'b0001, 32'hC0, 32'h40,  32'h40);
        tbl[9]  = mk(0, 4'b0001, 0, 32'h0,  0, 5'd12, 32'h0,   0,  0, 4'b0000, 32'hC0, 32'h103, 32'h40);
        tbl[10] = mk(0, 4'b0001, 0, 32'h0,  1, 5'd13, 32'h100, 1,  0, 4'b0000, 32'hC0, 32'h100, 32'h40);
        tbl[11] = mk(0, 4'b0001, 0, 32'h0,  0, 5'd12, 32'h0,   0,  0, 4'b0000, 32'hC0, 32'h101, 32'h40);
        tbl[12] = mk(0, 4'b0001, 0, 32'h0,  1, 5'd12, 32'hF05, 0,  0, 4'b0000, 32'hC0, 32'h101, 32'h40);
        tbl[13] = mk(0, 4'b1010, 0, 32'h0,  0, 5'd12, 32'h0,   0,  0, 4'b0000, 32'hC0, 32'hF05, 32'h40);
        tbl[14] = mk(0, 4'b1010, 0, 32'h80, 0, 5'd13, 32'h0,   0,  1, 4'b0000, 32'hC8, 32'hA00, 32'h40);
        tbl[15] = mk(0, 4'b1010, 0, 32'h0,  0, 5'd13, 32'h0,   0,  0, 4'b0010, 32'hC8, 32'hA04, 32'h80);

        // Hand sequences: new edge in service + W1C/eret re-take, reset after take,
        // intctrl blocking with an MTC0 discarded by the take.
        seq[0]  = mk(0, 4'b1110, 0, 32'h0,   0, 5'd13, 32'h0,    0, 0, 4'b0000, 32'hC8, 32'hA04, 32'h80);
        seq[1]  = mk(0, 4'b1110, 0, 32'h0,   0, 5'd13, 32'h0,    0, 0, 4'b0000, 32'hC8, 32'hE04, 32'h80);
        seq[2]  = mk(0, 4'b1110, 0, 32'h0,   1, 5'd13, 32'h200,  1, 0, 4'b0000, 32'hC8, 32'hE04, 32'h80);
        seq[3]  = mk(0, 4'b1110, 0, 32'h100, 0, 5'd13, 32'h0,    0, 1, 4'b0000, 32'hD0, 32'hC04, 32'h80);
        seq[4]  = mk(0, 4'b1110, 0, 32'h0,   0, 5'd13, 32'h0,    0, 0, 4'b0100, 32'hD0, 32'hC08, 32'h100);
        seq[5]  = mk(0, 4'b1110, 0, 32'h0,   0, 5'd12, 32'h0,    0, 0, 4'b0000, 32'hD0, 32'hF07, 32'h100);
        seq[6]  = mk(1, 4'b0000, 0, 32'h0,   0, 5'd12, 32'h0,    0, 0, 4'b0000, 32'hD0, 32'hF07, 32'h100);
        seq[7]  = mk(0, 4'b0000, 0, 32'h0,   0, 5'd12, 32'h0,    0, 0, 4'b0000, 32'hC0, 32'h0,   32'h0);
        seq[8]  = mk(0, 4'b0000, 0, 32'h0,   0, 5'd13, 32'h0,    0, 0, 4'b0000, 32'hC0, 32'h0,   32'h0);
        seq[9]  = mk(0, 4'b0000, 0, 32'h0,   0, 5'd14, 32'h0,    0, 0, 4'b0000, 32'hC0, 32'h0,   32'h0);
        seq[10] = mk(0, 4'b0001, 0, 32'h0,   0, 5'd13, 32'h0,    0, 0, 4'b0000, 32'hC0, 32'h0,   32'h0);
        seq[11] = mk(0, 4'b0001, 0, 32'h0,   1, 5'd12, 32'h101,  0, 0, 4'b0000, 32'hC0, 32'h0,   32'h0);
        seq[12] = mk(0, 4'b0001, 1, 32'h200, 0, 5'd13, 32'h0,    0, 0, 4'b0000, 32'hC0, 32'h100, 32'h0);
        seq[13] = mk(0, 4'b0001, 1, 32'h200, 0, 5'd13, 32'h0,    0, 0, 4'b0000, 32'hC0, 32'h100, 32'h0);
        seq[14] = mk(0, 4'b0001, 1, 32'h200, 0, 5'd13, 32'h0,    0, 0, 4'b0000, 32'hC0, 32'h100, 32'h0);
        seq[15] = mk(0, 4'b0001, 0, 32'h200, 1, 5'd14, 32'h1234, 0, 1, 4'b0000, 32'hC0, 32'h0,   32'h0);
        seq[16] = mk(0, 4'b0001, 0, 32'h0,   0, 5'd14, 32'h0,    0, 0, 4'b0001, 32'hC0, 32'h200, 32'h200);
        // Re-take without W1C after eret; reset lands while irq_ack is high.
        seq[17] = mk(0, 4'b0001, 0, 32'h0,   0, 5'd12, 32'h0,    1, 0, 4'b0000, 32'hC0, 32'h103, 32'h200);
        seq[18] = mk(0, 4'b0001, 0, 32'h300, 0, 5'd12, 32'h0,    0, 1, 4'b0000, 32'hC0, 32'h101, 32'h200);
        seq[19] = mk(1, 4'b0001, 0, 32'h0,   0, 5'd12, 32'h0,    0, 0, 4'b0001, 32'hC0, 32'h103, 32'h300);
        seq[20] = mk(0, 4'b0000, 0, 32'h0,   0, 5'd12, 32'h0,    0, 0, 4'b0000, 32'hC0, 32'h0,   32'h0);

        rst = 1'b1; irq = '0; intctrl = 1'b0; pc = '0; we = 1'b0;
        addr = '0; wd = '0; eret = 1'b0;
        @(posedge clk);
        @(posedge clk);
        model_reset();
        #1;

        for (int k = 0; k < 16; k++) run_cycle(tbl[k], 1'b1, $sformatf("tbl%0d", k));
        for (int k = 0; k < 21; k++) run_cycle(seq[k], 1'b1, $sformatf("seq%0d", k));

        // Random phase, checked against the model only.
        irq_r = '0;
        for (int k = 0; k < 600; k++) begin
            int a;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(5) == 0) irq_r[b] = ~irq_r[b];
            end
            a          = int'($urandom_range(5));
            rv         = tbl[1];
            rv.rst     = ($urandom_range(99) == 0);
            rv.irq     = irq_r;
            rv.intctrl = ($urandom_range(3) == 0);
            rv.pc      = $urandom;
            rv.we      = ($urandom_range(3) == 0);
            rv.addr    = (a < 3) ? 5'(12 + a) : 5'($urandom_range(31));
            rv.wd      = $urandom;
            rv.eret    = ($urandom_range(4) == 0);
            run_cycle(rv, 1'b0, $sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
